// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the serial BCD to binary converter
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        FIN  = 2'd2
    } bcd_state_t;

    localparam int BCD_MAX_DIGIT = 9;
    localparam int NIBBLE_W      = 4;

endpackage

// File: rtl/bcd_digito_mac.sv
// rtl/bcd_digito_mac.sv - one decimal step: acc_out = acc_in*10 + digit, flags invalid digit
// Ports: acc_in (ACC_W) running accumulator, digit (4) incoming BCD nibble,
//        acc_out (ACC_W) updated accumulator, invalid high when digit > 9.
module bcd_digito_mac
    import bcd_pkg::*;
#(
    parameter int ACC_W = 18
) (
    input  logic [ACC_W-1:0]    acc_in,
    input  logic [NIBBLE_W-1:0] digit,
    output logic [ACC_W-1:0]    acc_out,
    output logic                invalid
);

    // x*10 = x*8 + x*2, so no multiplier is inferred.
    assign acc_out = (acc_in << 3) + (acc_in << 1) + {{(ACC_W-NIBBLE_W){1'b0}}, digit};
    assign invalid = (digit > NIBBLE_W'(BCD_MAX_DIGIT));

endmodule

// File: rtl/bcd_a_binario_serial.sv
// rtl/bcd_a_binario_serial.sv - packed BCD to unsigned binary, one digit per clock, MSB first
// Ports: clk, rst_n (async active-low), start request pulse, bcd_in packed BCD word
//        (bits [3:0] least significant digit), busy, done single-cycle pulse,
//        binario result (held until next done), error (any nibble > 9 in last word).
module bcd_a_binario_serial
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [NIBBLE_W*DIGITS-1:0]   bcd_in,
    output logic                         busy,
    output logic                         done,
    output logic [BIN_W-1:0]             binario,
    output logic                         error
);

    localparam int SR_W  = NIBBLE_W * DIGITS;
    // Four spare bits keep the *10 step from wrapping before truncation.
    localparam int ACC_W = BIN_W + 4;
    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    bcd_state_t          state;
    logic [SR_W-1:0]     shift_reg;
    logic [ACC_W-1:0]    acc;
    logic [CNT_W-1:0]    digit_cnt;
    logic                err_flag;

    logic [ACC_W-1:0]    acc_next;
    logic                digit_invalid;

    bcd_digito_mac #(
        .ACC_W (ACC_W)
    ) u_mac (
        .acc_in  (acc),
        .digit   (shift_reg[SR_W-1 -: NIBBLE_W]),
        .acc_out (acc_next),
        .invalid (digit_invalid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            acc       <= '0;
            digit_cnt <= '0;
            err_flag  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            binario   <= '0;
            error     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        shift_reg <= bcd_in;
                        acc       <= '0;
                        digit_cnt <= CNT_W'(DIGITS - 1);
                        err_flag  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= CONV;
                    end
                end
                CONV: begin
                    acc       <= acc_next;
                    shift_reg <= shift_reg << NIBBLE_W;
                    err_flag  <= err_flag | digit_invalid;
                    if (digit_cnt == '0) begin
                        // Results are registered here so they are valid during FIN,
                        // the cycle in which done is high.
                        done    <= 1'b1;
                        error   <= err_flag | digit_invalid;
                        binario <= (err_flag | digit_invalid) ? '0 : acc_next[BIN_W-1:0];
                        state   <= FIN;
                    end else begin
                        digit_cnt <= digit_cnt - 1'b1;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_a_binario_serial.sv
// tb/tb_bcd_a_binario_serial.sv - self-checking bench for bcd_a_binario_serial
module tb_bcd_a_binario_serial;

    localparam int DIGITS = 4;
    localparam int BIN_W  = 14;

    logic                  clk;
    logic                  rst_n;
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic [BIN_W-1:0]      binario;
    logic                  error;

    typedef struct packed {
        logic [BIN_W-1:0] bin;
        logic             err;
    } exp_t;

    exp_t sb[$];
    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;
    int   t_start = 0;

    bcd_a_binario_serial #(
        .DIGITS (DIGITS),
        .BIN_W  (BIN_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .binario (binario),
        .error   (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_conv(input logic [15:0] bcd, input logic [BIN_W-1:0] bin, input logic err);
        exp_t e;
        @(negedge clk);
        bcd_in = bcd;
        start  = 1'b1;
        e.bin  = bin;
        e.err  = err;
        sb.push_back(e);
        @(posedge clk);
        #1;
        t_start = cyc;
        start   = 1'b0;
    endtask

    // Waits (bounded) for done, then pops the scoreboard and compares.
    task automatic wait_check(input bit chk_lat, output int done_cyc);
        int   n;
        bit   seen;
        int   busy_low;
        exp_t e;
        n = 0; seen = 0; busy_low = 0; done_cyc = 0;
        while (!seen && n < 30) begin
            @(negedge clk);
            n++;
            if (done) seen = 1;
            else if (!busy) busy_low++;
        end
        check("done_seen", 32'(seen), 32'd1);
        if (seen) begin
            done_cyc = cyc;
            if (chk_lat) check("latency", 32'(cyc - t_start), 32'(DIGITS));
            check("busy_low_before_done", 32'(busy_low), 32'd0);
            check("busy_at_done", 32'(busy), 32'd1);
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'(sb.size()));
            end else begin
                e = sb.pop_front();
                check("binario", 32'(binario), 32'(e.bin));
                check("error", 32'(error), 32'(e.err));
            end
            @(negedge clk);
            check("done_single_cycle", 32'(done), 32'd0);
            check("busy_after_fin", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        int d1;
        int d2;
        int done_cnt;
        rst_n  = 1'b1;
        start  = 1'b1;
        bcd_in = 16'h5555;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_binario", 32'(binario), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_rst_busy", 32'(busy), 32'd0);

        start_conv(16'h1234, 14'd1234, 1'b0);
        wait_check(1, d1);
        start_conv(16'h9999, 14'd9999, 1'b0);
        wait_check(1, d1);
        start_conv(16'h0000, 14'd0, 1'b0);
        wait_check(1, d1);
        start_conv(16'h12A4, 14'd0, 1'b1);
        wait_check(1, d1);
        start_conv(16'h0042, 14'd42, 1'b0);
        wait_check(1, d1);
        start_conv(16'hF000, 14'd0, 1'b1);
        wait_check(1, d1);

        // Ignored start and changed bcd_in during a conversion.
        start_conv(16'h0500, 14'd500, 1'b0);
        @(negedge clk);
        bcd_in = 16'h7777;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        wait_check(1, d1);

        // start held high: back-to-back conversions spaced DIGITS+2 cycles.
        @(negedge clk);
        bcd_in = 16'h0321;
        start  = 1'b1;
        sb.push_back('{bin: 14'd321, err: 1'b0});
        sb.push_back('{bin: 14'd321, err: 1'b0});
        @(posedge clk);
        #1;
        t_start = cyc;
        wait_check(1, d1);
        wait_check(0, d2);
        start = 1'b0;
        check("held_start_spacing", 32'(d2 - d1), 32'(DIGITS + 2));

        // Asynchronous reset in the middle of a conversion.
        @(negedge clk);
        bcd_in = 16'h0999;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        check("async_rst_binario", 32'(binario), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("no_done_after_rst", 32'(done_cnt), 32'd0);
        start_conv(16'h0007, 14'd7, 1'b0);
        wait_check(1, d1);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
